// File: rtl/bps_dispatch.sv
// Round-robin dispatcher that shares one BP-S master among NREQ requesters.
// It grants one job, issues it to the master, tracks the ack/run handshake and reports completion.
module bps_dispatch #(
  parameter int NREQ   = 4,
  parameter int ITER_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ-1:0]        req_kind,
  input  logic [3*NREQ-1:0]      req_instr,
  input  logic [ITER_W*NREQ-1:0] req_iter,
  output logic [NREQ-1:0]        req_ready,
  output logic [NREQ-1:0]        done,
  output logic                   busy,
  output logic                   err,
  output logic [15:0]            job_count,
  output logic                   m_start,
  output logic [2:0]             m_instruction,
  output logic [ITER_W-1:0]      m_iterations,
  input  logic                   m_stall
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {IDLE, ISSUE, ACK, RUN, DONE} state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [PTR_W-1:0]    owner_q, owner_d;
  logic                kind_q, kind_d;
  logic [2:0]          instr_q, instr_d;
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic                ack_miss_q, ack_miss_d;
  logic                err_q, err_d;
  logic [15:0]         count_q, count_d;

  logic [2:0]          instr_arr [NREQ];
  logic [ITER_W-1:0]   iter_arr  [NREQ];
  logic                found;
  logic [PTR_W-1:0]    winner;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      instr_arr[i] = req_instr[3*i +: 3];
      iter_arr[i]  = req_iter[ITER_W*i +: ITER_W];
    end
  end

  // First valid requester at or after the pointer, wrapping around.
  always_comb begin : arb
    int idx;
    logic [PTR_W-1:0] idx_c;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    idx_c  = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      idx_c = PTR_W'(idx);
      if (!found && req_valid[idx_c]) begin
        found  = 1'b1;
        winner = idx_c;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    owner_d       = owner_q;
    kind_d        = kind_q;
    instr_d       = instr_q;
    iter_d        = iter_q;
    ack_miss_d    = ack_miss_q;
    err_d         = err_q;
    count_d       = count_q;
    req_ready     = '0;
    done          = '0;
    m_start       = 1'b0;
    m_instruction = 3'b000;
    case (state_q)
      IDLE: begin
        if (found && !m_stall && !rst) begin
          req_ready[winner] = 1'b1;
          owner_d = winner;
          kind_d  = req_kind[winner];
          instr_d = instr_arr[winner];
          // A zero iteration count would wrap the master's down-counter.
          iter_d  = (req_kind[winner] && iter_arr[winner] == '0) ? ITER_W'(1) : iter_arr[winner];
          ptr_d   = (int'(winner) == NREQ - 1) ? '0 : winner + 1'b1;
          state_d = (!req_kind[winner] && instr_arr[winner] == 3'b000) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        m_start       = kind_q;
        m_instruction = kind_q ? 3'b000 : instr_q;
        ack_miss_d    = 1'b0;
        state_d       = ACK;
      end
      ACK: begin
        if (m_stall) begin
          state_d = RUN;
        end else if (ack_miss_q) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          ack_miss_d = 1'b1;
        end
      end
      RUN: begin
        if (!m_stall) state_d = DONE;
      end
      DONE: begin
        done[owner_q] = 1'b1;
        if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      kind_q     <= 1'b0;
      instr_q    <= 3'b000;
      iter_q     <= '0;
      ack_miss_q <= 1'b0;
      err_q      <= 1'b0;
      count_q    <= 16'd0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      kind_q     <= kind_d;
      instr_q    <= instr_d;
      iter_q     <= iter_d;
      ack_miss_q <= ack_miss_d;
      err_q      <= err_d;
      count_q    <= count_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign err          = err_q;
  assign job_count    = count_q;
  assign m_iterations = iter_q;

endmodule
